// File: rtl/p_cache_lookup_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : p_cache_lookup_fill_pkg                                 |
// | Description : FSM state encoding and tree pseudo-LRU helpers shared   |
// |               by the cache lookup/fill slice.                         |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package p_cache_lookup_fill_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_MISS   = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  // Helpers work on a fixed maximum-size tree; callers cast to their width.
  localparam int MAX_WAYS = 16;
  localparam int MAX_LVL  = 4;

  typedef logic [MAX_WAYS-2:0] plru_t;
  typedef logic [4:0]          node_t;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right);
  // leaves start at ways-1. A set bit steers the victim to the right.
  function automatic node_t plru_victim(input plru_t bits, input int ways);
    node_t node;
    plru_t sh;
    node = '0;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (node < node_t'(ways - 1)) begin
        sh = bits >> node;
        if (sh[0]) node = (node << 1) + 5'd2;
        else       node = (node << 1) + 5'd1;
      end
    end
    return node - node_t'(ways - 1);
  endfunction

  // Walk from the accessed leaf to the root, pointing each node away.
  function automatic plru_t plru_update(input plru_t bits, input node_t way, input int ways);
    node_t node;
    node_t parent;
    logic  dir;
    node = way + node_t'(ways - 1);
    for (int l = 0; l < MAX_LVL; l++) begin
      if (node != '0) begin
        parent = (node - 5'd1) >> 1;
        dir    = node[0];  // odd node = left child, so victim goes right
        bits   = (bits & ~(plru_t'(1) << parent)) | (plru_t'(dir) << parent);
        node   = parent;
      end
    end
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_cache_lookup_fill_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : p_cache_lookup_fill_if                                  |
// | Description : Fetch request/response and line-wide memory port of the |
// |               lookup/fill cache. master = fetch + memory side.        |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface p_cache_lookup_fill_if #(
  parameter int S_OFFSET = 5,
  parameter int NUM_WAYS = 4
) ();
  localparam int LINE_W = 8 * (2 ** S_OFFSET);

  logic                req_valid;
  logic [31:0]         req_addr;
  logic                ready;
  logic                resp_valid;
  logic [LINE_W-1:0]   resp_line;
  logic [NUM_WAYS-1:0] resp_way;
  logic                flush;
  logic                pmem_read;
  logic [31:0]         pmem_address;
  logic [LINE_W-1:0]   pmem_rdata;
  logic                pmem_resp;

  modport master (
    output req_valid, req_addr, flush, pmem_rdata, pmem_resp,
    input  ready, resp_valid, resp_line, resp_way, pmem_read, pmem_address
  );

  modport slave (
    input  req_valid, req_addr, flush, pmem_rdata, pmem_resp,
    output ready, resp_valid, resp_line, resp_way, pmem_read, pmem_address
  );
endinterface
`default_nettype wire

// File: rtl/p_cache_lookup_fill_way_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : p_cache_way_array                                       |
// | Description : One cache way: valid bits, tags and line data with a    |
// |               registered read port and a single write port.           |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module p_cache_way_array #(
  parameter int S_INDEX = 3,
  parameter int S_TAG   = 24,
  parameter int LINE_W  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic [S_INDEX-1:0] rd_idx_i,
  input  logic               we_i,
  input  logic [S_INDEX-1:0] wr_idx_i,
  input  logic [S_TAG-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i,
  output logic               valid_o,
  output logic [S_TAG-1:0]   tag_o,
  output logic [LINE_W-1:0]  data_o
);
  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [NUM_SETS-1:0] valid_q;
  logic [S_TAG-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic                valid_rd_q;
  logic [S_TAG-1:0]    tag_rd_q;
  logic [LINE_W-1:0]   data_rd_q;

  // Valid bits: cleared by reset or flush, set by a fill.
  always_ff @(posedge clk) begin
    if (rst || clr_i) valid_q <= '0;
    else if (we_i)    valid_q[wr_idx_i] <= 1'b1;
  end

  // Tag and data storage carry no reset; validity gates their use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Registered read of the valid bit (reset so the first compare is clean).
  always_ff @(posedge clk) begin
    if (rst) valid_rd_q <= 1'b0;
    else     valid_rd_q <= valid_q[rd_idx_i];
  end

  // Registered read of tag and data; read-before-write on the same set.
  always_ff @(posedge clk) begin
    tag_rd_q  <= tag_q[rd_idx_i];
    data_rd_q <= data_q[rd_idx_i];
  end

  assign valid_o = valid_rd_q;
  assign tag_o   = tag_rd_q;
  assign data_o  = data_rd_q;
endmodule
`default_nettype wire

// File: rtl/p_cache_lookup_fill.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : p_cache_lookup_fill                                     |
// | Description : N-way set-associative read-only cache: two-stage        |
// |               lookup, tree PLRU, miss/fill FSM with replay, flush.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module p_cache_lookup_fill
  import p_cache_lookup_fill_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  p_cache_lookup_fill_if.slave cache_io
);
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int LINE_W   = 8 * (2 ** S_OFFSET);
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int PLRU_W   = NUM_WAYS - 1;
  localparam int LA_W     = 32 - S_OFFSET;

  state_e              state_q, state_d;
  logic                s2_valid_q, s2_valid_d;
  logic [LA_W-1:0]     s2_line_q, s2_line_d;
  logic                flush_pend_q, flush_pend_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [PLRU_W-1:0]   plru_q [NUM_SETS];

  logic [S_INDEX-1:0]  w_s2_idx;
  logic [S_TAG-1:0]    w_s2_tag;
  logic [S_INDEX-1:0]  w_req_idx;
  logic [S_INDEX-1:0]  w_rd_idx;
  logic [NUM_WAYS-1:0] w_way_valid;
  logic [S_TAG-1:0]    w_way_tag  [NUM_WAYS];
  logic [LINE_W-1:0]   w_way_data [NUM_WAYS];
  logic [NUM_WAYS-1:0] w_tag_match;
  logic                w_lookup_ok;
  logic [NUM_WAYS-1:0] w_hit_vec;
  logic                w_hit;
  logic                w_miss;
  logic [LINE_W-1:0]   w_hit_line;
  logic [WAY_W-1:0]    w_hit_idx;
  logic                w_any_inv;
  logic [WAY_W-1:0]    w_first_inv;
  logic [WAY_W-1:0]    w_plru_way;
  logic                w_ready;
  logic                w_fill_we;
  logic                w_arr_clr;
  logic                w_plru_en;
  logic [WAY_W-1:0]    w_plru_upd_way;
  logic                w_unused_ok;

  assign w_s2_idx    = s2_line_q[S_INDEX-1:0];
  assign w_s2_tag    = s2_line_q[LA_W-1:S_INDEX];
  assign w_req_idx   = cache_io.req_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_unused_ok = ^cache_io.req_addr[S_OFFSET-1:0];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    p_cache_way_array #(
      .S_INDEX (S_INDEX),
      .S_TAG   (S_TAG),
      .LINE_W  (LINE_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (w_arr_clr),
      .rd_idx_i  (w_rd_idx),
      .we_i      (w_fill_we && (victim_q == WAY_W'(w))),
      .wr_idx_i  (w_s2_idx),
      .wr_tag_i  (w_s2_tag),
      .wr_data_i (cache_io.pmem_rdata),
      .valid_o   (w_way_valid[w]),
      .tag_o     (w_way_tag[w]),
      .data_o    (w_way_data[w])
    );
    assign w_tag_match[w] = w_way_valid[w] && (w_way_tag[w] == w_s2_tag);
  end

  // A flush sampled in LOOKUP drops the stage-2 request without a response.
  assign w_lookup_ok = (state_q == ST_LOOKUP) && s2_valid_q && !cache_io.flush;
  assign w_hit_vec   = w_lookup_ok ? w_tag_match : '0;
  assign w_hit       = |w_hit_vec;
  assign w_miss      = w_lookup_ok && !(|w_tag_match);
  assign w_plru_way  = WAY_W'(plru_victim(plru_t'(plru_q[w_s2_idx]), NUM_WAYS));

  // Hit-way data mux and lowest-invalid-way search.
  always_comb begin
    w_hit_line  = '0;
    w_hit_idx   = '0;
    w_any_inv   = 1'b0;
    w_first_inv = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (w_hit_vec[w]) begin
        w_hit_line = w_hit_line | w_way_data[w];
        w_hit_idx  = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) begin
        w_any_inv   = 1'b1;
        w_first_inv = WAY_W'(w);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d        = state_q;
    s2_valid_d     = s2_valid_q;
    s2_line_d      = s2_line_q;
    flush_pend_d   = flush_pend_q;
    victim_d       = victim_q;
    w_ready        = 1'b0;
    w_fill_we      = 1'b0;
    w_arr_clr      = 1'b0;
    w_plru_en      = 1'b0;
    w_plru_upd_way = victim_q;
    w_rd_idx       = w_s2_idx;
    unique case (state_q)
      ST_LOOKUP: begin
        if (cache_io.flush) begin
          s2_valid_d   = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (w_miss) begin
          victim_d = w_any_inv ? w_first_inv : w_plru_way;
          state_d  = ST_MISS;
        end else begin
          if (w_hit) begin
            w_plru_en      = 1'b1;
            w_plru_upd_way = w_hit_idx;
          end
          // A flush deferred during a miss runs right after its response.
          if (flush_pend_q) begin
            s2_valid_d   = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = ST_FLUSH;
          end else begin
            w_ready    = 1'b1;
            s2_valid_d = cache_io.req_valid;
            if (cache_io.req_valid) begin
              s2_line_d = cache_io.req_addr[31:S_OFFSET];
              w_rd_idx  = w_req_idx;
            end
          end
        end
      end
      ST_MISS: begin
        if (cache_io.flush) flush_pend_d = 1'b1;
        if (cache_io.pmem_resp) begin
          w_fill_we = 1'b1;
          w_plru_en = 1'b1;
          state_d   = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        if (cache_io.flush) flush_pend_d = 1'b1;
        state_d = ST_LOOKUP;
      end
      ST_FLUSH: begin
        w_arr_clr  = 1'b1;
        s2_valid_d = 1'b0;
        state_d    = ST_LOOKUP;
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOOKUP;
      s2_valid_q   <= 1'b0;
      s2_line_q    <= '0;
      flush_pend_q <= 1'b0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      s2_valid_q   <= s2_valid_d;
      s2_line_q    <= s2_line_d;
      flush_pend_q <= flush_pend_d;
      victim_q     <= victim_d;
    end
  end

  // Per-set PLRU bits: cleared by reset/flush, updated on hit or fill.
  always_ff @(posedge clk) begin
    if (rst || w_arr_clr) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (w_plru_en) begin
      plru_q[w_s2_idx] <= PLRU_W'(plru_update(plru_t'(plru_q[w_s2_idx]),
                                              node_t'(w_plru_upd_way), NUM_WAYS));
    end
  end

  assign cache_io.ready        = w_ready;
  assign cache_io.resp_valid   = w_hit;
  assign cache_io.resp_line    = w_hit_line;
  assign cache_io.resp_way     = w_hit_vec;
  assign cache_io.pmem_read    = (state_q == ST_MISS);
  assign cache_io.pmem_address = {s2_line_q, {S_OFFSET{1'b0}}};
endmodule
`default_nettype wire
